if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS 5-stage pipeline.
- Owns the fetch PC and drives a variable-latency instruction-memory request/ack port.
- Holds one fetched word and presents it to the IF/ID boundary with a valid flag.
- Obeys the pipeline controller's if_en/if_rst, and applies ID-stage redirects (pc_src) with MIPS branch-delay-slot semantics.

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/ack port between the fetch stage (master) and imem (slave).
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage with variable-latency imem port and delay-slot redirects.
// Defining IF_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_en,
    input  logic              if_rst,
    input  logic [2:0]        pc_src,
    input  logic              id_en,
    input  logic              id_valid,
    input  logic [31:0]       inst_id,
    input  logic [ADDR_W-1:0] pc_id,
    input  logic [31:0]       rs_data_id,
    if_fetch_stage_if.master  imem,
    output logic [31:0]       inst_if,
    output logic [ADDR_W-1:0] pc_if,
    output logic              if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;
    state_t            state, state_n;
    logic              pend_v, redir, consume, unused_ok;
    logic [ADDR_W-1:0] pend_pc, fetch_pc, pc_id4, target, next_pc;
    assign unused_ok = &{1'b0, inst_id[31:26]};
    assign pc_id4 = pc_id + ADDR_W'(4);
    assign target = pc_src == 3'd1 ? {pc_id4[ADDR_W-1:28], inst_id[25:0], 2'b00}
                  : pc_src == 3'd2 ? rs_data_id[ADDR_W-1:0]
                  : pc_id4 + {{(ADDR_W-18){inst_id[15]}}, inst_id[15:0], 2'b00};
    assign redir = id_valid && id_en && pc_src != 3'd0 && !if_rst && state != S_DROP;
    assign next_pc = redir ? target : pend_v ? pend_pc : fetch_pc + ADDR_W'(4);
    assign consume = state == S_HOLD && if_en;
    assign imem.imem_req = !rst && (state != S_HOLD || if_en);
    assign imem.imem_addr = state == S_HOLD ? next_pc : fetch_pc;
    always_ff @(posedge clk)
        state <= rst ? S_REQ : state_n;
    always_comb begin
        state_n = state;
        if (if_rst)
            state_n = (imem.imem_req && !imem.imem_ack) ? S_DROP : S_REQ;
        else if (state == S_REQ && imem.imem_ack)
            state_n = S_HOLD;
        else if (consume && !imem.imem_ack)
            state_n = S_REQ;
        else if (state == S_DROP && imem.imem_ack)
            state_n = S_REQ;
    end
    // A redirect seen while not issuing is parked until the next issue; last one wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pend_v   <= 1'b0;
            pend_pc  <= '0;
            inst_if  <= '0;
            pc_if    <= '0;
            if_valid <= 1'b0;
        end else if (if_rst) begin
            if_valid <= 1'b0;
            pend_v   <= 1'b0;
        end else begin
            if (consume) begin
                fetch_pc <= next_pc;
                pend_v   <= 1'b0;
                if_valid <= imem.imem_ack;
            end else if (redir) begin
                pend_v  <= 1'b1;
                pend_pc <= target;
            end
            if (imem.imem_ack && (state == S_REQ || consume)) begin
                inst_if  <= imem.imem_rdata;
                pc_if    <= imem.imem_addr;
                if_valid <= 1'b1;
            end
        end
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + {31'b0, if_valid && if_en};
            stall_cnt <= stall_cnt + {31'b0, state != S_HOLD && !imem.imem_ack};
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed table, hand sequences and random run against a reference model.
module tb_if_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, if_en, if_rst, id_en, id_valid;
    logic [2:0] pc_src;
    logic [31:0] inst_id, pc_id, rs_data_id;
    logic [31:0] inst0, pc0, inst1, pc1;
    logic v0, v1;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fc0, sc0, fc1, sc1;
`endif
    if_fetch_stage_if #(.ADDR_W(32)) m0 ();
    if_fetch_stage_if #(.ADDR_W(32)) m1 ();
    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    assign m0.imem_rdata = mw(m0.imem_addr);
    assign m1.imem_rdata = mw(m1.imem_addr);
    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst), .if_en(if_en), .if_rst(if_rst), .pc_src(pc_src),
        .id_en(id_en), .id_valid(id_valid), .inst_id(inst_id), .pc_id(pc_id),
        .rs_data_id(rs_data_id), .imem(m0), .inst_if(inst0), .pc_if(pc0), .if_valid(v0)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fc0), .stall_cnt(sc0)
`endif
    );
    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h100)) dut1 (
        .clk(clk), .rst(rst), .if_en(if_en), .if_rst(if_rst), .pc_src(pc_src),
        .id_en(id_en), .id_valid(id_valid), .inst_id(inst_id), .pc_id(pc_id),
        .rs_data_id(rs_data_id), .imem(m1), .inst_if(inst1), .pc_if(pc1), .if_valid(v1)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fc1), .stall_cnt(sc1)
`endif
    );
    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    typedef struct {
        logic en, frst, idv;
        logic [2:0] src;
        logic [31:0] inst, pcid, rs;
        logic ack, ereq;
        logic [31:0] eaddr;
        logic ev;
        logic [31:0] epc;
    } vec_t;
    function automatic vec_t mk(input logic en, frst, idv, input logic [2:0] src,
                                input logic [31:0] inst, pcid, rs, input logic ack, ereq,
                                input logic [31:0] eaddr, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.en = en; v.frst = frst; v.idv = idv; v.src = src; v.inst = inst; v.pcid = pcid;
        v.rs = rs; v.ack = ack; v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc;
        return v;
    endfunction
    task automatic idle();
        if_en = 1'b1; if_rst = 1'b0; id_valid = 1'b0; id_en = 1'b1; pc_src = 3'd0;
        inst_id = '0; pc_id = '0; rs_data_id = '0;
    endtask
    // Reference model state: held word, discard-in-progress flag, parked redirect.
    logic [31:0] m_fpc, m_pend, m_inst, m_pc, m_fc, m_sc, jt, tgt, nxt, eaddr;
    logic m_pend_v, m_held, m_drop, m_v, redir, ereq, ack;
    task automatic model_reset();
        m_fpc = 32'h0; m_pend = '0; m_pend_v = 1'b0; m_held = 1'b0; m_drop = 1'b0;
        m_v = 1'b0; m_inst = '0; m_pc = '0; m_fc = '0; m_sc = '0;
    endtask
    vec_t tv[23];
    initial begin
        for (int i = 0; i < 10; i++)
            tv[i] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'(4 * i), i > 0, i > 0 ? 32'(4 * (i - 1)) : 32'h0);
        tv[10] = mk(1, 0, 1, 3, 32'h1022_0004, 32'h20, 0, 1, 1, 32'h34, 1, 32'h24);
        tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h38, 1, 32'h34);
        for (int i = 12; i < 16; i++)
            tv[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h38);
        tv[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3C, 1, 32'h38);
        tv[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 32'h3C);
        tv[18] = mk(1, 1, 1, 2, 0, 32'h3C, 32'h900, 0, 1, 32'h40, 0, 32'h3C);
        tv[19] = mk(1, 0, 1, 1, 32'h0800_0100, 32'h40, 0, 0, 1, 32'h40, 0, 32'h3C);
        tv[20] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h3C);
        tv[21] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h3C);
        tv[22] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h44, 1, 32'h40);
        rst = 1'b1; idle(); m0.imem_ack = 1'b0; m1.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0", {31'b0, m0.imem_req}, 0);
        chk("rst_req1", {31'b0, m1.imem_req}, 0);
        chk("rst_valid", {31'b0, v0}, 0);
        chk("rst_inst", inst0, 0);
        chk("rst_pc", pc0, 0);
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if_en = tv[i].en; if_rst = tv[i].frst; id_valid = tv[i].idv; pc_src = tv[i].src;
            inst_id = tv[i].inst; pc_id = tv[i].pcid; rs_data_id = tv[i].rs; m0.imem_ack = tv[i].ack;
            #1;
            chk($sformatf("tv%0d_req", i), {31'b0, m0.imem_req}, {31'b0, tv[i].ereq});
            if (tv[i].ereq) chk($sformatf("tv%0d_addr", i), m0.imem_addr, tv[i].eaddr);
            chk($sformatf("tv%0d_valid", i), {31'b0, v0}, {31'b0, tv[i].ev});
            chk($sformatf("tv%0d_pc_if", i), pc0, tv[i].epc);
            if (tv[i].ev) chk($sformatf("tv%0d_inst_if", i), inst0, mw(tv[i].epc));
        end
`ifdef IF_PERF_CNT_EN
        chk("tv_fetch_cnt", fc0, 13);
        chk("tv_stall_cnt", sc0, 2);
`endif
        @(negedge clk);
        rst = 1'b1; idle(); m1.imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lat%0d_req", k), {31'b0, m1.imem_req}, 1);
            chk($sformatf("lat%0d_addr", k), m1.imem_addr, 32'h100);
            chk($sformatf("lat%0d_valid", k), {31'b0, v1}, 0);
            @(negedge clk);
        end
        m1.imem_ack = 1'b1;
        #1 chk("lat_ack_addr", m1.imem_addr, 32'h100);
        @(negedge clk);
        m1.imem_ack = 1'b0;
        #1;
        chk("lat_pc_if", pc1, 32'h100);
        chk("lat_valid", {31'b0, v1}, 1);
        chk("lat_inst_if", inst1, mw(32'h100));
        chk("lat_next_addr", m1.imem_addr, 32'h104);
        @(negedge clk);
        id_valid = 1'b1; pc_src = 3'd2; pc_id = 32'h100; rs_data_id = 32'h400;
        #1;
        chk("jr_pend_addr", m1.imem_addr, 32'h104);
        chk("jr_pend_valid", {31'b0, v1}, 0);
        @(negedge clk);
        idle(); m1.imem_ack = 1'b1;
        #1 chk("jr_slot_addr", m1.imem_addr, 32'h104);
        @(negedge clk);
        #1;
        chk("jr_slot_pc", pc1, 32'h104);
        chk("jr_slot_valid", {31'b0, v1}, 1);
        chk("jr_target_addr", m1.imem_addr, 32'h400);
`ifdef IF_PERF_CNT_EN
        chk("jr_stall_cnt", sc1, 4);
`endif
        @(negedge clk);
        rst = 1'b1; idle(); m0.imem_ack = 1'b0;
        @(negedge clk);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = $urandom_range(0, 199) == 0;
            if_en = $urandom_range(0, 3) != 0;
            if_rst = $urandom_range(0, 19) == 0;
            id_valid = 1'($urandom);
            id_en = $urandom_range(0, 3) != 0;
            pc_src = $urandom_range(0, 5) < 3 ? 3'd0 : 3'($urandom_range(1, 3));
            inst_id = $urandom;
            pc_id = $urandom & ~32'h3;
            rs_data_id = $urandom & ~32'h3;
            m0.imem_ack = 1'($urandom);
            #1;
            jt = pc_id + 4;
            tgt = pc_src == 3'd1 ? {jt[31:28], inst_id[25:0], 2'b00}
                : pc_src == 3'd2 ? rs_data_id
                : jt + 32'($signed(inst_id[15:0])) * 4;
            redir = !rst && !if_rst && !m_drop && id_valid && id_en && pc_src != 3'd0;
            nxt = redir ? tgt : m_pend_v ? m_pend : m_fpc + 4;
            ereq = !rst && (!m_held || if_en);
            eaddr = m_held ? nxt : m_fpc;
            chk("rnd_req", {31'b0, m0.imem_req}, {31'b0, ereq});
            if (ereq) chk("rnd_addr", m0.imem_addr, eaddr);
            chk("rnd_valid", {31'b0, v0}, {31'b0, m_v});
            chk("rnd_pc_if", pc0, m_pc);
            chk("rnd_inst_if", inst0, m_inst);
`ifdef IF_PERF_CNT_EN
            chk("rnd_fetch_cnt", fc0, m_fc);
            chk("rnd_stall_cnt", sc0, m_sc);
`endif
            ack = m0.imem_ack;
            if (rst) model_reset();
            else begin
                m_fc = m_fc + {31'b0, m_v && if_en};
                m_sc = m_sc + {31'b0, !m_held && !ack};
                if (if_rst) begin
                    m_v = 1'b0; m_pend_v = 1'b0; m_drop = ereq && !ack; m_held = 1'b0;
                end else if (m_drop) m_drop = !ack;
                else if (!m_held) begin
                    if (redir) begin m_pend_v = 1'b1; m_pend = tgt; end
                    if (ack) begin m_inst = mw(m_fpc); m_pc = m_fpc; m_v = 1'b1; m_held = 1'b1; end
                end else if (if_en) begin
                    m_fpc = nxt; m_pend_v = 1'b0; m_held = ack; m_v = ack;
                    if (ack) begin m_inst = mw(nxt); m_pc = nxt; end
                end else if (redir) begin
                    m_pend_v = 1'b1; m_pend = tgt;
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
